mips_mem_arbiter: RTL
=====================

Name: mips_mem_arbiter

Overview:
- Shares one single-ported, variable-latency memory between two requesters of the multicycle MIPS core.
- The instruction-fetch requester (I-port) issues reads only; the data requester (D-port) issues lw/sw.
- The block arbitrates between the two, drives the memory request/ack handshake, and bounds D-port priority so fetch cannot starve.
- A timeout aborts any stalled memory access.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, max cycles in a wait state without mem_ack before abort (>=2)
- D_BURST_MAX, 4, max consecutive D grants while i_req is pending (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- i_req  in  1  fetch request; held with i_addr until i_ack
- i_addr  in  ADDR_W  fetch address
- i_ack  out  1  one-cycle pulse; i_rdata valid this cycle
- i_rdata  out  DATA_W  fetched word, registered
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle pulse; d_rdata valid this cycle (loads)
- d_rdata  out  DATA_W  loaded word, registered
- mem_req  out  1  memory request, held until mem_ack or abort
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion; mem_rdata valid the same cycle
- mem_rdata  in  DATA_W  memory read data
- timeout_err  out  1  sticky abort flag
- busy  out  1  state != IDLE

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - On reset: state=IDLE; every output=0; d_streak=0; wait counter=0.
  - Reset mid-transaction abandons it: mem_req=0 at the next edge, no ack issued, timeout_err cleared.
- All outputs are registered.
- States: IDLE, WAIT_I, WAIT_D, ACK.
- IDLE grant rule, evaluated every cycle:
  - D wins if d_req && (!i_req || d_streak < D_BURST_MAX).
  - Otherwise I wins if i_req.
  - Otherwise stay in IDLE.
- On a grant:
  - Latch the request fields into mem_addr/mem_we/mem_wdata and set mem_req=1 at the next edge.
  - I grant: mem_we=0, mem_wdata=0, d_streak=0, go to WAIT_I.
  - D grant: d_streak=min(d_streak+1, D_BURST_MAX), go to WAIT_D.
- WAIT_x:
  - Hold mem_* stable.
  - If mem_ack=1: capture mem_rdata into x_rdata, pulse x_ack at the next edge, drop mem_req/mem_we, go to ACK.
  - Otherwise increment the wait counter.
- Timeout: wait counter reaches TIMEOUT-1 with mem_ack=0:
  - Drop mem_req, set x_rdata=0, pulse x_ack, set timeout_err=1 (held until rst), go to ACK.
  - mem_ack arriving in the same cycle as the timeout threshold counts as success.
- ACK:
  - The ack pulse is visible; requests are ignored this cycle because the requester's req is still high.
  - Clear the wait counter, go to IDLE.
- Minimum latency: req sampled in IDLE at cycle t; mem_req=1 at t+1; mem_ack at t+1 gives x_ack=1 at t+2.
  - Back-to-back grants for one requester: one every 3 cycles minimum.
- mem_ack is ignored in IDLE and ACK.
- i_rdata/d_rdata keep their last value between acks.
- Requests arriving during WAIT/ACK wait for IDLE.
- The un-granted requester's req stays pending.
- A simultaneous i_req and d_req with d_streak < D_BURST_MAX grants D.

Test Plan:
1. i_req, i_addr=0x0000_0040, mem_ack 3 cycles after mem_req with mem_rdata=0x2008_0005 -> mem_addr=0x40, mem_we=0, i_ack high exactly one cycle, i_rdata=0x2008_0005, busy low two cycles after i_ack.
2. i_req and d_req rise the same cycle in IDLE (d_we=0, d_addr=0x100), mem_ack immediate -> D granted first, d_ack at t+2, then I granted, i_ack at t+5.
3. D_BURST_MAX=4, d_req re-asserted immediately after every d_ack, i_req held high, mem_ack immediate -> grants D,D,D,D,I,D...; d_streak resets after the I grant.
4. Store d_we=1, d_addr=0x0000_0100, d_wdata=0xCAFE_F00D -> mem_we=1, mem_addr=0x100, mem_wdata=0xCAFEF00D held until mem_ack; d_ack one pulse; mem_we=0 afterwards.
5. TIMEOUT=16, d_req load, mem_ack never asserted -> mem_req drops after 16 cycles high, d_ack pulses with d_rdata=0, timeout_err=1 stays high through later successful transfers until rst.
6. rst asserted 2 cycles into WAIT_I -> next edge: mem_req=0, i_ack never pulses, state IDLE, timeout_err=0; a fresh i_req afterwards completes normally.

Source files
------------

// File: rtl/mips_mem_arbiter_if.sv
// Bus bundle between the MIPS fetch/data requesters, the arbiter and the shared memory.
// slave  : arbiter view (serves both requesters and drives the memory request).
// master : environment view (core requesters plus the memory model).
interface mips_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // Instruction-fetch port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  // Data port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  // Memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  // Status
  logic              timeout_err;
  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
    output timeout_err, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
    input  timeout_err, busy
  );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory between the fetch (I) and
// data (D) requesters of the multicycle MIPS core. D has priority for at most D_BURST_MAX
// consecutive grants while a fetch is pending; a stalled access is aborted after TIMEOUT
// wait cycles and flagged through a sticky timeout_err.
module mips_mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned D_BURST_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  mips_mem_arbiter_if.slave   arb_bus
);

  localparam int unsigned CNT_W    = $clog2(TIMEOUT);
  localparam int unsigned STREAK_W = $clog2(D_BURST_MAX + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT_I = 2'd1;
  localparam logic [1:0] ST_WAIT_D = 2'd2;
  localparam logic [1:0] ST_ACK    = 2'd3;

  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(D_BURST_MAX);

  // Registered state
  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [STREAK_W-1:0] r_d_streak;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_i_ack;
  logic [DATA_W-1:0]   r_i_rdata;
  logic                r_d_ack;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_timeout_err;
  logic                r_busy;

  // Next-state values
  logic [1:0]          w_state_nxt;
  logic [CNT_W-1:0]    w_wait_cnt_nxt;
  logic [STREAK_W-1:0] w_d_streak_nxt;
  logic                w_mem_req_nxt;
  logic                w_mem_we_nxt;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic [DATA_W-1:0]   w_mem_wdata_nxt;
  logic                w_i_ack_nxt;
  logic [DATA_W-1:0]   w_i_rdata_nxt;
  logic                w_d_ack_nxt;
  logic [DATA_W-1:0]   w_d_rdata_nxt;
  logic                w_timeout_err_nxt;
  logic                w_busy_nxt;

  logic                w_d_grant;
  logic                w_timeout_hit;

  // D wins unless a fetch is pending and D has used up its burst allowance
  assign w_d_grant     = arb_bus.d_req && (!arb_bus.i_req || (r_d_streak < STREAK_MAX));
  assign w_timeout_hit = (r_wait_cnt == CNT_LAST);

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_d_streak_nxt    = r_d_streak;
    w_mem_req_nxt     = r_mem_req;
    w_mem_we_nxt      = r_mem_we;
    w_mem_addr_nxt    = r_mem_addr;
    w_mem_wdata_nxt   = r_mem_wdata;
    w_i_ack_nxt       = 1'b0;
    w_i_rdata_nxt     = r_i_rdata;
    w_d_ack_nxt       = 1'b0;
    w_d_rdata_nxt     = r_d_rdata;
    w_timeout_err_nxt = r_timeout_err;

    case (r_state)
      ST_IDLE: begin
        if (w_d_grant) begin
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = arb_bus.d_we;
          w_mem_addr_nxt  = arb_bus.d_addr;
          w_mem_wdata_nxt = arb_bus.d_wdata;
          if (r_d_streak != STREAK_MAX) begin
            w_d_streak_nxt = r_d_streak + STREAK_W'(1);
          end
          w_state_nxt = ST_WAIT_D;
        end else if (arb_bus.i_req) begin
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = arb_bus.i_addr;
          w_mem_wdata_nxt = '0;
          w_d_streak_nxt  = '0;
          w_state_nxt     = ST_WAIT_I;
        end
      end

      ST_WAIT_I, ST_WAIT_D: begin
        // mem_ack on the threshold cycle still counts as a successful access
        if (arb_bus.mem_ack) begin
          if (r_state == ST_WAIT_I) begin
            w_i_ack_nxt   = 1'b1;
            w_i_rdata_nxt = arb_bus.mem_rdata;
          end else begin
            w_d_ack_nxt   = 1'b1;
            w_d_rdata_nxt = arb_bus.mem_rdata;
          end
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
          w_state_nxt   = ST_ACK;
        end else if (w_timeout_hit) begin
          if (r_state == ST_WAIT_I) begin
            w_i_ack_nxt   = 1'b1;
            w_i_rdata_nxt = '0;
          end else begin
            w_d_ack_nxt   = 1'b1;
            w_d_rdata_nxt = '0;
          end
          w_mem_req_nxt     = 1'b0;
          w_mem_we_nxt      = 1'b0;
          w_timeout_err_nxt = 1'b1;
          w_state_nxt       = ST_ACK;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
      end

      ST_ACK: begin
        // Requester's req is still high this cycle; it is re-evaluated from IDLE
        w_wait_cnt_nxt = '0;
        w_state_nxt    = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and output registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_wait_cnt    <= '0;
      r_d_streak    <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_i_ack       <= 1'b0;
      r_i_rdata     <= '0;
      r_d_ack       <= 1'b0;
      r_d_rdata     <= '0;
      r_timeout_err <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_d_streak    <= w_d_streak_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_mem_we      <= w_mem_we_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
      r_i_ack       <= w_i_ack_nxt;
      r_i_rdata     <= w_i_rdata_nxt;
      r_d_ack       <= w_d_ack_nxt;
      r_d_rdata     <= w_d_rdata_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign arb_bus.i_ack       = r_i_ack;
  assign arb_bus.i_rdata     = r_i_rdata;
  assign arb_bus.d_ack       = r_d_ack;
  assign arb_bus.d_rdata     = r_d_rdata;
  assign arb_bus.mem_req     = r_mem_req;
  assign arb_bus.mem_we      = r_mem_we;
  assign arb_bus.mem_addr    = r_mem_addr;
  assign arb_bus.mem_wdata   = r_mem_wdata;
  assign arb_bus.timeout_err = r_timeout_err;
  assign arb_bus.busy        = r_busy;

endmodule
